hermes_switch_crossbar: RTL

Parametrised successor to the Hermes combinational crossbar. It adds per-output switch allocation with round-robin arbitration and packet-length tracking. Each output holds its connection for a whole Hermes packet (header flit, size flit, payload flits) and releases it automatically after the last flit. It sits between the input buffers and the output links of a Hermes router; the routing unit supplies a requested output port per input.

---
 rtl/hermes_switch_crossbar.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/hermes_switch_crossbar.sv
// hermes_switch_crossbar
//   Hermes router crossbar with per-output switch allocation. Each output runs
//   a small FSM (FREE -> HDR -> SIZE -> PAYLOAD). The FSM picks one requesting
//   input by round-robin and keeps that connection for a whole packet: the
//   header flit, the size flit, then size-many payload flits. It releases the
//   output on its own after the last flit.
//
// Ports
//   clock, reset : clock and synchronous active-high reset
//   data_av      : per input, a valid flit is present
//   data_in      : per input flit, input i at [i*FLIT_W +: FLIT_W]
//   req          : per input, the flit at the head is a header requesting an output
//   req_port     : per input requested output index, at [i*PW +: PW]
//   credit_i     : per output, downstream can accept a flit
//   tx           : per output flit valid
//   data_out     : per output flit
//   data_ack     : per input, the flit was consumed this cycle
//   out_busy     : per output, allocated to an input
//   out_sel      : per output, connected input index (0 when free)
//   err_turn     : sticky flag, a request targeted a forbidden or nonexistent output
module hermes_switch_crossbar #(
  parameter int NPORTS = 5,
  parameter int FLIT_W = 16,
  parameter logic [NPORTS*NPORTS-1:0] TURN_MASK = 25'h0FBDEF7
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NPORTS-1:0]                data_av,
  input  logic [NPORTS*FLIT_W-1:0]         data_in,
  input  logic [NPORTS-1:0]                req,
  input  logic [NPORTS*$clog2(NPORTS)-1:0] req_port,
  input  logic [NPORTS-1:0]                credit_i,
  output logic [NPORTS-1:0]                tx,
  output logic [NPORTS*FLIT_W-1:0]         data_out,
  output logic [NPORTS-1:0]                data_ack,
  output logic [NPORTS-1:0]                out_busy,
  output logic [NPORTS*$clog2(NPORTS)-1:0] out_sel,
  output logic                             err_turn
);

  localparam int PW = $clog2(NPORTS);

  typedef enum logic [1:0] {ST_FREE, ST_HDR, ST_SIZE, ST_PAYLOAD} state_e;

  state_e             state_q [NPORTS];
  state_e             state_d [NPORTS];
  logic [PW-1:0]      sel_q   [NPORTS];
  logic [PW-1:0]      sel_d   [NPORTS];
  logic [PW-1:0]      ptr_q   [NPORTS];
  logic [PW-1:0]      ptr_d   [NPORTS];
  logic [FLIT_W-1:0]  cnt_q   [NPORTS];
  logic [FLIT_W-1:0]  cnt_d   [NPORTS];
  logic               err_q, err_d;

  logic [NPORTS-1:0]  in_conn;            // input already owns some output
  logic [NPORTS-1:0]  legal;              // requested output exists and turn allowed
  logic [NPORTS-1:0]  illegal;
  logic [NPORTS-1:0]  elig [NPORTS];      // elig[j][i]: input i competes for output j
  logic [NPORTS-1:0]  grant_vld;
  logic [PW-1:0]      grant_idx [NPORTS];
  logic [NPORTS-1:0]  xfer;
  int                 rr_i;

  // Connection map comes from registered state only, so an input released in
  // one cycle may compete again in the very next cycle.
  always_comb begin
    in_conn = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (state_q[j] != ST_FREE) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (sel_q[j] == PW'(i)) in_conn[i] = 1'b1;
        end
      end
    end
  end

  // Request decode. Matching req_port against each legal output index keeps
  // the TURN_MASK lookup in range even for req_port >= NPORTS.
  always_comb begin
    legal   = '0;
    illegal = '0;
    for (int j = 0; j < NPORTS; j++) elig[j] = '0;
    for (int i = 0; i < NPORTS; i++) begin
      for (int j = 0; j < NPORTS; j++) begin
        if (req_port[i*PW +: PW] == PW'(j) && TURN_MASK[i*NPORTS+j]) begin
          legal[i]   = 1'b1;
          elig[j][i] = req[i] & data_av[i] & ~in_conn[i];
        end
      end
      illegal[i] = req[i] & data_av[i] & ~in_conn[i] & ~legal[i];
    end
  end

  // Round-robin: first eligible input at or after ptr, wrapping modulo NPORTS.
  always_comb begin
    rr_i = 0;
    for (int j = 0; j < NPORTS; j++) begin
      grant_vld[j] = 1'b0;
      grant_idx[j] = '0;
      for (int k = 0; k < NPORTS; k++) begin
        rr_i = (int'(ptr_q[j]) + k) % NPORTS;
        if (!grant_vld[j] && elig[j][rr_i]) begin
          grant_vld[j] = 1'b1;
          grant_idx[j] = PW'(rr_i);
        end
      end
    end
  end

  // Combinational datapath through the established connections.
  always_comb begin
    tx       = '0;
    data_out = '0;
    data_ack = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (state_q[j] != ST_FREE) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (sel_q[j] == PW'(i)) begin
            tx[j]                        = data_av[i];
            data_out[j*FLIT_W +: FLIT_W] = data_in[i*FLIT_W +: FLIT_W];
            data_ack[i]                  = credit_i[j] & data_av[i];
          end
        end
      end
    end
  end

  assign xfer = tx & credit_i;

  // Per-output allocation FSM, next-state logic.
  always_comb begin
    err_d = err_q | (|illegal);
    for (int j = 0; j < NPORTS; j++) begin
      state_d[j] = state_q[j];
      sel_d[j]   = sel_q[j];
      ptr_d[j]   = ptr_q[j];
      cnt_d[j]   = cnt_q[j];
      case (state_q[j])
        ST_FREE: begin
          if (grant_vld[j]) begin
            state_d[j] = ST_HDR;
            sel_d[j]   = grant_idx[j];
            ptr_d[j]   = (grant_idx[j] == PW'(NPORTS-1)) ? '0 : grant_idx[j] + PW'(1);
          end
        end
        ST_HDR: begin
          if (xfer[j]) state_d[j] = ST_SIZE;
        end
        ST_SIZE: begin
          if (xfer[j]) begin
            cnt_d[j] = data_out[j*FLIT_W +: FLIT_W];
            if (data_out[j*FLIT_W +: FLIT_W] == '0) begin
              state_d[j] = ST_FREE;   // empty packet: header + size only
              sel_d[j]   = '0;
            end else begin
              state_d[j] = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer[j]) begin
            cnt_d[j] = cnt_q[j] - FLIT_W'(1);
            if (cnt_q[j] == FLIT_W'(1)) begin
              state_d[j] = ST_FREE;
              sel_d[j]   = '0;
            end
          end
        end
        default: state_d[j] = ST_FREE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
      for (int j = 0; j < NPORTS; j++) begin
        state_q[j] <= ST_FREE;
        sel_q[j]   <= '0;
        ptr_q[j]   <= '0;
        cnt_q[j]   <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int j = 0; j < NPORTS; j++) begin
        state_q[j] <= state_d[j];
        sel_q[j]   <= sel_d[j];
        ptr_q[j]   <= ptr_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_out
      assign out_busy[gi]          = (state_q[gi] != ST_FREE);
      assign out_sel[gi*PW +: PW]  = sel_q[gi];
    end
  endgenerate

  assign err_turn = err_q;

endmodule
